// File: rtl/breadboard_sweeper.sv
// breadboard_sweeper
// Walks a 4-input combinational breadboard through codes 0..15. For each code
// it waits SETTLE cycles and then offers the 10 breadboard outputs as one row.
// Rows go out in ascending code order.
//
// Handshake: a row transfers on a rising edge where row_valid & row_ready are
// both high. While row_valid is high, row_idx/row_data stay stable until that
// transfer. An abort in the same cycle cancels the transfer.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request a sweep (only looked at in IDLE)
//   abort           cancel an active sweep, return to IDLE with no done pulse
//   w, x, y, z      breadboard inputs, {w,x,y,z} = current code
//   r_in[9:0]       breadboard outputs r0..r9
//   row_valid       captured row is on offer
//   row_ready       consumer accepts the row
//   row_idx[3:0]    code of the offered row
//   row_data[9:0]   captured r_in
//   busy            high while in WAIT or OFFER
//   done            one-cycle pulse after the last row is accepted
//   state_dbg[1:0]  current FSM state (IDLE=0, WAIT=1, OFFER=2, DONE=3)
//   sig[15:0]       row signature; exists only with BREADBOARD_SIGNATURE_EN
//
// Parameter SETTLE (1..15): cycles from applying a code to sampling r_in.
// Macro BREADBOARD_SIGNATURE_EN adds the sig port and its signature register.
module breadboard_sweeper #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  input  logic [9:0]  r_in,
  output logic        row_valid,
  input  logic        row_ready,
  output logic [3:0]  row_idx,
  output logic [9:0]  row_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
`ifdef BREADBOARD_SIGNATURE_EN
  ,
  output logic [15:0] sig
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_OFFER = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic        valid_d;
  logic [3:0]  ridx_d;
  logic [9:0]  rdata_d;
  logic        busy_d;
  logic        done_d;
`ifdef BREADBOARD_SIGNATURE_EN
  logic [15:0] sig_q, sig_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = row_valid;
    ridx_d  = row_idx;
    rdata_d = row_data;
    done_d  = 1'b0;
`ifdef BREADBOARD_SIGNATURE_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          code_d  = 4'd0;
          state_d = S_WAIT;
`ifdef BREADBOARD_SIGNATURE_EN
          sig_d   = 16'd0;
`endif
        end
      end
      S_WAIT: begin
        if (abort) begin
          valid_d = 1'b0;
          code_d  = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          rdata_d = r_in;
          ridx_d  = idx_q;
          valid_d = 1'b1;
          state_d = S_OFFER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_OFFER: begin
        // abort takes priority: the row on offer is dropped, not accepted
        if (abort) begin
          valid_d = 1'b0;
          code_d  = 4'd0;
          state_d = S_IDLE;
        end else if (row_ready) begin
          valid_d = 1'b0;
`ifdef BREADBOARD_SIGNATURE_EN
          sig_d   = {sig_q[14:0], sig_q[15]} ^ {6'b0, row_data};
`endif
          if (idx_q == 4'd15) begin
            // done is registered, so it is high during the DONE cycle
            code_d  = 4'd0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            code_d  = idx_q + 4'd1;
            cnt_d   = 4'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_WAIT) || (state_d == S_OFFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      cnt_q     <= 4'd0;
      code_q    <= 4'd0;
      row_valid <= 1'b0;
      row_idx   <= 4'd0;
      row_data  <= 10'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BREADBOARD_SIGNATURE_EN
      sig_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      row_valid <= valid_d;
      row_idx   <= ridx_d;
      row_data  <= rdata_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef BREADBOARD_SIGNATURE_EN
      sig_q     <= sig_d;
`endif
    end
  end

  assign w = code_q[3];
  assign x = code_q[2];
  assign y = code_q[1];
  assign z = code_q[0];
  assign state_dbg = state_q;
`ifdef BREADBOARD_SIGNATURE_EN
  assign sig = sig_q;
`endif

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Testbench for breadboard_sweeper. Main instance uses SETTLE=2 with a
// scoreboard of expected rows; two extra instances (SETTLE=1, SETTLE=15)
// have their row timing checked cycle by cycle.
module tb_breadboard_sweeper;

  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- breadboard model ----------------
  function automatic logic [9:0] bb(input logic [3:0] c);
    case (c)
      4'd0:    bb = 10'h020;
      4'd1:    bb = 10'h041;
      4'd2:    bb = 10'h082;
      4'd3:    bb = 10'h0C3;
      4'd4:    bb = 10'h104;
      4'd5:    bb = 10'h145;
      4'd6:    bb = 10'h186;
      4'd7:    bb = 10'h1C7;
      4'd8:    bb = 10'h208;
      4'd9:    bb = 10'h249;
      4'd10:   bb = 10'h28A;
      4'd11:   bb = 10'h2CB;
      4'd12:   bb = 10'h30C;
      4'd13:   bb = 10'h34D;
      4'd14:   bb = 10'h38E;
      default: bb = 10'h11F;
    endcase
  endfunction

  // ---------------- main DUT (SETTLE=2) ----------------
  logic start = 1'b0, abort = 1'b0, row_ready = 1'b1, tie_one = 1'b0;
  wire w, x, y, z, row_valid, busy, done;
  wire [3:0] row_idx;
  wire [9:0] row_data;
  wire [1:0] state_dbg;
  wire [3:0] code = {w, x, y, z};
  wire [9:0] r_in = tie_one ? 10'h001 : bb(code);
`ifdef BREADBOARD_SIGNATURE_EN
  wire [15:0] sig, sig1, sig15;
`endif

  breadboard_sweeper #(.SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .w(w), .x(x), .y(y), .z(z), .r_in(r_in),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .row_data(row_data), .busy(busy), .done(done), .state_dbg(state_dbg)
`ifdef BREADBOARD_SIGNATURE_EN
    , .sig(sig)
`endif
  );

  // ---------------- timing instances (SETTLE=1, SETTLE=15) ----------------
  logic start_t = 1'b0;
  wire [3:0] c1, c15, i1, i15;
  wire [9:0] d1, d15;
  wire v1, v15, b1, b15, dn1, dn15;
  wire [1:0] st1, st15;

  breadboard_sweeper #(.SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_t), .abort(1'b0),
    .w(c1[3]), .x(c1[2]), .y(c1[1]), .z(c1[0]), .r_in(bb(c1)),
    .row_valid(v1), .row_ready(1'b1), .row_idx(i1), .row_data(d1),
    .busy(b1), .done(dn1), .state_dbg(st1)
`ifdef BREADBOARD_SIGNATURE_EN
    , .sig(sig1)
`endif
  );

  breadboard_sweeper #(.SETTLE(15)) dut_s15 (
    .clk(clk), .rst_n(rst_n), .start(start_t), .abort(1'b0),
    .w(c15[3]), .x(c15[2]), .y(c15[1]), .z(c15[0]), .r_in(bb(c15)),
    .row_valid(v15), .row_ready(1'b1), .row_idx(i15), .row_data(d15),
    .busy(b15), .done(dn15), .state_dbg(st15)
`ifdef BREADBOARD_SIGNATURE_EN
    , .sig(sig15)
`endif
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];   // {row_idx, row_data}
  logic        prev_stall = 1'b0;
  logic [3:0]  prev_idx;
  logic [9:0]  prev_data;
  logic [13:0] exp_row;

  // Samples 1 time unit after the falling edge: outputs are stable and the
  // inputs for the next rising edge have been driven.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", row_valid, 1'b1);
        check("stall_idx", row_idx, prev_idx);
        check("stall_data", row_data, prev_data);
        check("stall_code", code, prev_idx);
      end
      if (row_valid) check("code_matches_row", code, row_idx);
      if (row_valid && row_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          exp_row = exp_q.pop_front();
          check("row_idx", row_idx, exp_row[13:10]);
          check("row_data", row_data, exp_row[9:0]);
        end
      end
      prev_stall = row_valid && !row_ready && !abort;
      prev_idx   = row_idx;
      prev_data  = row_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the falling edge right after the edge that accepted start.
  task automatic sweep_start();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({4'(i), tie_one ? 10'h001 : bb(4'(i))});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int t);
    t = t0;
    while (!done && t < t0 + 400) begin
      @(negedge clk);
      t++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_row(input logic [3:0] n);
    int k = 0;
    while (!(row_valid && row_idx == n) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("row_timeout", 0, 1);
  endtask

  function automatic bit vexp(input int t, input int s);
    return (t >= s) && (t < s + 16 * (s + 1)) && (((t - s) % (s + 1)) == 0);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_valid", row_valid, 0);
    check("rst_idx", row_idx, 0);
    check("rst_data", row_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_code", code, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full sweep, ready always high
    row_ready = 1'b1;
    sweep_start();
    check("start_busy", busy, 1);
    check("start_code", code, 0);
    @(negedge clk);
    check("row0_not_yet", row_valid, 0);
    @(negedge clk);
    check("row0_valid_k2", row_valid, 1);
    check("row0_data", row_data, 10'h020);
    wait_done(2, t);
    check("done_at_k48", t, 48);
    check("done_code", code, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", state_dbg, ST_IDLE);
    check("idle_busy", busy, 0);
    check("sb_empty_sweep", exp_q.size(), 0);

    // back-pressure on row 3
    sweep_start();
    wait_row(4'd3);
    row_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_code", code, 4'b0011);
      check("bp_valid", row_valid, 1);
    end
    row_ready = 1'b1;
    wait_done(0, t);
    @(negedge clk);
    check("sb_empty_bp", exp_q.size(), 0);

    // start during sweep is ignored; abort on handshake of row 7
    sweep_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_row(4'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", row_valid, 0);
    check("abort_code", code, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_state", state_dbg, ST_IDLE);
    check("abort_rows_left", exp_q.size(), 9);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    exp_q.delete();

    // abort together with start in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_state", state_dbg, ST_IDLE);

    // reset during OFFER of row 5
    sweep_start();
    wait_row(4'd5);
    row_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", row_valid, 0);
    check("mrst_idx", row_idx, 0);
    check("mrst_data", row_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_code", code, 0);
    check("mrst_state", state_dbg, ST_IDLE);
    check("mrst_rows_left", exp_q.size(), 11);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    row_ready = 1'b1;
    sweep_start();
    check("after_rst_code", code, 0);
    wait_done(0, t);
    check("after_rst_done_k48", t, 48);
    @(negedge clk);
    check("sb_empty_rst", exp_q.size(), 0);

    // row timing for SETTLE=1 and SETTLE=15
    @(negedge clk);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    for (int tt = 1; tt <= 259; tt++) begin
      @(negedge clk);
      check("s1_valid", v1, vexp(tt, 1));
      if (v1 && vexp(tt, 1)) begin
        check("s1_idx", i1, (tt - 1) / 2);
        check("s1_data", d1, bb(4'((tt - 1) / 2)));
      end
      check("s1_done", dn1, tt == 32);
      check("s15_valid", v15, vexp(tt, 15));
      if (v15 && vexp(tt, 15)) begin
        check("s15_idx", i15, (tt - 15) / 16);
        check("s15_data", d15, bb(4'((tt - 15) / 16)));
      end
      check("s15_done", dn15, tt == 256);
    end

`ifdef BREADBOARD_SIGNATURE_EN
    // signature with r_in tied to 0x001
    tie_one = 1'b1;
    sweep_start();
    check("sig_cleared", sig, 16'h0000);
    wait_done(0, t);
    check("sig_final", sig, 16'hFFFF);
    @(negedge clk);
    check("sig_held", sig, 16'hFFFF);
    tie_one = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
